ifft_frame_ctrl: RTL and testbench
==================================

Name: ifft_frame_ctrl

Overview:
- Frame sequencer between the OFDM subcarrier mapper and the streaming IFFT core (10-bit in, 14-bit out, variable size up to 16 points).
- Cuts the upstream sample stream into N-point frames with sop/eop, holds fftpts_in/inverse stable per frame and limits frames in flight.
- Passes core output downstream while checking frame integrity and counting completed symbols.

Parameters:
- DW_IN, 10, upstream/core-sink sample width per rail
- DW_OUT, 14, core-source/downstream sample width per rail
- NPTS_W, 5, width of point-count fields (N up to 16)
- MAX_OUTSTANDING, 2, maximum frames accepted by the core but not yet fully output (1..3)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset; the top level drives core reset_n = ~reset
- enable  in  1  allows new frames to start
- cfg_npts  in  NPTS_W  frame size; legal values 4, 8, 16
- cfg_inverse  in  1  1 = IFFT, 0 = FFT
- err_clr  in  1  clears sticky error flags
- in_valid / in_ready  in / out  1 / 1  upstream handshake
- in_real, in_imag  in  DW_IN  upstream sample
- sink_valid, sink_sop, sink_eop  out  1  core sink controls
- sink_ready  in  1  core backpressure
- sink_error  out  2  tied to 0
- sink_real, sink_imag  out  DW_IN  core sink data
- fftpts_in  out  NPTS_W  frame size to core
- inverse  out  1  transform direction to core
- source_valid, source_sop, source_eop  in  1  core output
- source_ready  out  1  core output backpressure
- source_error  in  2  core error
- source_real, source_imag  in  DW_OUT  core output data
- fftpts_out  in  NPTS_W  output frame size from core
- out_valid, out_sop, out_eop  out  1  downstream
- out_ready  in  1  downstream backpressure
- out_real, out_imag  out  DW_OUT  downstream data
- outstanding  out  2  frames in flight
- sym_count  out  16  completed output frames, wraps at 65535 -> 0
- cfg_err, framing_err, core_err  out  1  sticky flags

Behaviour:
- Reset values: state IDLE; fftpts_in = 16; inverse = 1; outstanding = 0; sym_count = 0; all error flags 0. In IDLE, sink_valid = 0 and in_ready = 0.
- Sink FSM, IDLE -> SEND when enable & in_valid & outstanding < MAX_OUTSTANDING.
  - On that transition: latch fftpts_in = cfg_npts and inverse = cfg_inverse; clear beat count.
  - If cfg_npts is illegal: latch 16 and set cfg_err.
- SEND:
  - sink_valid = in_valid; in_ready = sink_ready; sink_real/imag = in_real/imag (combinational).
  - Transfer = sink_valid & sink_ready.
  - sink_sop = (beat == 0); sink_eop = (beat == fftpts_in - 1).
  - beat increments on each transfer.
  - On eop transfer: go to IDLE; outstanding increments.
  - Next frame may start the cycle after eop (one idle cycle between frames).
- fftpts_in and inverse are held constant from the transition into SEND until the next IDLE -> SEND transition. cfg changes mid-frame are ignored.
- Source path is combinational: out_valid = source_valid, source_ready = out_ready, out_sop/eop/real/imag = source_*. Zero latency.
- Source monitor counts output beats on source_valid & source_ready.
  - framing_err is set if source_sop ≠ (obeat == 0), or if source_eop ≠ (obeat == fftpts_out - 1).
  - On eop transfer: obeat clears, sym_count increments, outstanding decrements.
- Same-cycle input eop and output eop: outstanding unchanged.
- Output eop while outstanding = 0: framing_err set, outstanding stays 0 (no underflow).
- core_err is set on any transfer with source_error ≠ 0.
- err_clr clears all flags; a set condition in the same cycle wins over err_clr.
- Reset mid-frame: FSM goes to IDLE and all counters clear in the same edge. The partial frame is abandoned; the core is reset in parallel.
- Deasserting enable mid-frame does not abort the frame; only new starts are blocked.

Test Plan:
- cfg_npts = 8, cfg_inverse = 1, 8 continuous samples, sink_ready = 1 -> sop on beat 0, eop on beat 7, fftpts_in = 8, inverse = 1, outstanding = 1; core returns 8 beats -> sym_count = 1, outstanding = 0.
- cfg_npts = 16, sink_ready toggling 1/0 each cycle -> exactly 16 transfers, sop/eop only on the accepted first/last beats, in_ready mirrors sink_ready.
- MAX_OUTSTANDING = 2, three frames queued, core output stalled (out_ready = 0) -> third frame not started (in_ready = 0, outstanding = 2) until the first output eop, then it starts.
- cfg_npts = 5 -> fftpts_in = 16, cfg_err = 1; err_clr pulse -> cfg_err = 0.
- Core output with source_eop at beat 3 of an 8-point frame -> framing_err = 1; source_error = 2'b01 on a beat -> core_err = 1.
- reset asserted at beat 4 of a 16-point frame -> next cycle sink_valid = 0, outstanding = 0, sym_count = 0, fftpts_in = 16.

Source files
------------

// File: rtl/ifft_frame_ctrl_if.sv
// ----------------------------------------------------------------------------
// ifft_frame_ctrl_if
// Framed complex-sample stream, matching the sink and source sides of the
// streaming IFFT core.
//   valid/ready  : handshake; a beat moves when both are high
//   sop/eop      : first/last beat of a frame
//   error        : 2-bit core error code
//   re/im        : sample rails, DW bits each
//   npts         : frame size in points (fftpts_in on sink, fftpts_out on source)
// The master modport produces the stream and the slave modport consumes it.
// ----------------------------------------------------------------------------
interface ifft_frame_ctrl_if #(
  parameter int DW     = 10,
  parameter int NPTS_W = 5
);
  logic              valid;
  logic              ready;
  logic              sop;
  logic              eop;
  logic [1:0]        error;
  logic [DW-1:0]     re;
  logic [DW-1:0]     im;
  logic [NPTS_W-1:0] npts;

  modport master (output valid, sop, eop, error, re, im, npts, input ready);
  modport slave  (input valid, sop, eop, error, re, im, npts, output ready);
endinterface

// File: rtl/ifft_frame_ctrl.sv
// ----------------------------------------------------------------------------
// ifft_frame_ctrl
// Frame sequencer between the OFDM subcarrier mapper and a streaming IFFT core.
// Cuts the upstream sample stream into N-point frames (sop/eop), holds the
// frame size and direction stable for each frame, and limits how many frames
// are in flight inside the core. The core output goes downstream with zero
// latency, while the frame structure is checked and completed symbols counted.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   core_reset_n      active-low reset to the core (= ~reset)
//   enable            allows new frames to start
//   cfg_npts          requested frame size (4, 8 or 16; other values -> 16)
//   cfg_inverse       requested direction (1 = IFFT)
//   err_clr           clears the sticky error flags
//   in_*              upstream stream (valid/ready/real/imag)
//   sink              stream into the core; sink.npts carries fftpts_in
//   inverse           transform direction to the core
//   source            stream out of the core; source.npts carries fftpts_out
//   out_*             downstream stream
//   outstanding       frames accepted by the core but not yet fully output
//   sym_count         completed output frames (wraps)
//   cfg_err, framing_err, core_err   sticky error flags
// ----------------------------------------------------------------------------
module ifft_frame_ctrl #(
  parameter int DW_IN           = 10,
  parameter int DW_OUT          = 14,
  parameter int NPTS_W          = 5,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic              core_reset_n,

  input  logic              enable,
  input  logic [NPTS_W-1:0] cfg_npts,
  input  logic              cfg_inverse,
  input  logic              err_clr,

  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW_IN-1:0]  in_real,
  input  logic [DW_IN-1:0]  in_imag,

  ifft_frame_ctrl_if.master sink,
  output logic              inverse,

  ifft_frame_ctrl_if.slave  source,

  output logic              out_valid,
  output logic              out_sop,
  output logic              out_eop,
  input  logic              out_ready,
  output logic [DW_OUT-1:0] out_real,
  output logic [DW_OUT-1:0] out_imag,

  output logic [1:0]        outstanding,
  output logic [15:0]       sym_count,
  output logic              cfg_err,
  output logic              framing_err,
  output logic              core_err
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  localparam logic [NPTS_W-1:0] NPTS_DEFAULT = NPTS_W'(16);
  localparam logic [NPTS_W-1:0] NPTS_ONE     = NPTS_W'(1);
  localparam logic [1:0]        MAX_OUT      = 2'(MAX_OUTSTANDING);

  logic [0:0]        state_reg;
  logic [NPTS_W-1:0] beat_reg;
  logic [NPTS_W-1:0] fftpts_reg;
  logic              inverse_reg;
  logic [1:0]        outstanding_reg;
  logic [NPTS_W-1:0] obeat_reg;
  logic [15:0]       sym_count_reg;
  logic              cfg_err_reg;
  logic              framing_err_reg;
  logic              core_err_reg;

  logic sending;
  logic npts_legal;
  logic start;
  logic in_xfer;
  logic in_eop_xfer;
  logic out_xfer;
  logic out_eop_xfer;
  logic frame_bad;
  logic underflow;

  assign core_reset_n = ~reset;

  // ---------------- sink side ----------------
  assign sending    = (state_reg == ST_SEND);
  assign npts_legal = (cfg_npts == NPTS_W'(4)) || (cfg_npts == NPTS_W'(8)) ||
                      (cfg_npts == NPTS_W'(16));
  assign start      = (state_reg == ST_IDLE) && enable && in_valid &&
                      (outstanding_reg < MAX_OUT);

  assign sink.valid = sending & in_valid;
  assign in_ready   = sending & sink.ready;
  assign sink.re    = in_real;
  assign sink.im    = in_imag;
  assign sink.sop   = sending && (beat_reg == '0);
  assign sink.eop   = sending && (beat_reg == fftpts_reg - NPTS_ONE);
  assign sink.error = 2'b00;
  assign sink.npts  = fftpts_reg;
  assign inverse    = inverse_reg;

  assign in_xfer     = sink.valid & sink.ready;
  assign in_eop_xfer = in_xfer & sink.eop;

  // ---------------- source side (pure pass-through) ----------------
  assign out_valid    = source.valid;
  assign out_sop      = source.sop;
  assign out_eop      = source.eop;
  assign out_real     = source.re;
  assign out_imag     = source.im;
  assign source.ready = out_ready;

  assign out_xfer     = source.valid & source.ready;
  assign out_eop_xfer = out_xfer & source.eop;

  // sop/eop must land exactly on the first/last beat of the announced size
  assign frame_bad = out_xfer &&
                     ((source.sop != (obeat_reg == '0)) ||
                      (source.eop != (obeat_reg == source.npts - NPTS_ONE)));
  // A frame ending while none is recorded in flight
  assign underflow = out_eop_xfer && (outstanding_reg == 2'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      beat_reg    <= '0;
      fftpts_reg  <= NPTS_DEFAULT;
      inverse_reg <= 1'b1;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg   <= ST_SEND;
            beat_reg    <= '0;
            fftpts_reg  <= npts_legal ? cfg_npts : NPTS_DEFAULT;
            inverse_reg <= cfg_inverse;
          end
        end
        default: begin
          if (in_xfer) begin
            if (sink.eop) begin
              state_reg <= ST_IDLE;
              beat_reg  <= '0;
            end else begin
              beat_reg <= beat_reg + NPTS_ONE;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding_reg <= 2'd0;
      obeat_reg       <= '0;
      sym_count_reg   <= 16'd0;
    end else begin
      // Simultaneous frame in and frame out cancel; never go below zero
      case ({in_eop_xfer, out_eop_xfer})
        2'b10:   outstanding_reg <= outstanding_reg + 2'd1;
        2'b01:   if (outstanding_reg != 2'd0) outstanding_reg <= outstanding_reg - 2'd1;
        default: outstanding_reg <= outstanding_reg;
      endcase
      if (out_xfer) begin
        if (source.eop) begin
          obeat_reg     <= '0;
          sym_count_reg <= sym_count_reg + 16'd1;
        end else begin
          obeat_reg <= obeat_reg + NPTS_ONE;
        end
      end
    end
  end

  // Sticky flags: a new error in the same cycle takes priority over err_clr
  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_err_reg     <= 1'b0;
      framing_err_reg <= 1'b0;
      core_err_reg    <= 1'b0;
    end else begin
      cfg_err_reg     <= (start && !npts_legal) || (cfg_err_reg && !err_clr);
      framing_err_reg <= frame_bad || underflow || (framing_err_reg && !err_clr);
      core_err_reg    <= (out_xfer && (source.error != 2'b00)) ||
                         (core_err_reg && !err_clr);
    end
  end

  assign outstanding = outstanding_reg;
  assign sym_count   = sym_count_reg;
  assign cfg_err     = cfg_err_reg;
  assign framing_err = framing_err_reg;
  assign core_err    = core_err_reg;

endmodule

// File: tb/tb_ifft_frame_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ifft_frame_ctrl
// Directed bench for ifft_frame_ctrl. Producers push the expected sink and
// downstream beats into queues as frames are issued; two monitors pop and
// compare whenever a beat transfers. Status registers are checked inline.
// ----------------------------------------------------------------------------
module tb_ifft_frame_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_reset_n;
  logic        enable;
  logic [4:0]  cfg_npts;
  logic        cfg_inverse;
  logic        err_clr;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  in_real, in_imag;
  logic        inverse;
  logic        out_valid, out_sop, out_eop, out_ready;
  logic [13:0] out_real, out_imag;
  logic [1:0]  outstanding;
  logic [15:0] sym_count;
  logic        cfg_err, framing_err, core_err;

  ifft_frame_ctrl_if #(.DW(10), .NPTS_W(5)) sink_bus ();
  ifft_frame_ctrl_if #(.DW(14), .NPTS_W(5)) src_bus ();

  ifft_frame_ctrl #(
    .DW_IN(10), .DW_OUT(14), .NPTS_W(5), .MAX_OUTSTANDING(2)
  ) dut (
    .clk(clk), .reset(reset), .core_reset_n(core_reset_n),
    .enable(enable), .cfg_npts(cfg_npts), .cfg_inverse(cfg_inverse),
    .err_clr(err_clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_real(in_real), .in_imag(in_imag),
    .sink(sink_bus), .inverse(inverse), .source(src_bus),
    .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
    .out_ready(out_ready), .out_real(out_real), .out_imag(out_imag),
    .outstanding(outstanding), .sym_count(sym_count),
    .cfg_err(cfg_err), .framing_err(framing_err), .core_err(core_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       sop;
    logic       eop;
    logic [9:0] re;
    logic [9:0] im;
    logic [4:0] npts;
    logic       inv;
  } sink_exp_t;

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [13:0] re;
    logic [13:0] im;
  } out_exp_t;

  sink_exp_t sink_q[$];
  out_exp_t  out_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  // Sink-side monitor: every accepted beat into the core
  initial begin
    sink_exp_t act, exp;
    forever begin
      @(negedge clk);
      if (sink_bus.valid === 1'b1 && sink_bus.ready === 1'b1) begin
        act = {sink_bus.sop, sink_bus.eop, sink_bus.re, sink_bus.im, sink_bus.npts, inverse};
        checks++;
        if (sink_q.size() == 0) begin
          failures++;
          $display("FAIL sink_unexpected actual=%0h required=none", act);
        end else begin
          exp = sink_q.pop_front();
          if (act !== exp) begin
            failures++;
            $display("FAIL sink_beat actual=%0h required=%0h at %0t", act, exp, $time);
          end else begin
            $display("sink beat sop=%0b eop=%0b re=%0h npts=%0d inv=%0b",
                     act.sop, act.eop, act.re, act.npts, act.inv);
          end
        end
      end
    end
  end

  // Downstream monitor: every beat leaving toward the next block
  initial begin
    out_exp_t act, exp;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        act = {out_sop, out_eop, out_real, out_imag};
        checks++;
        if (out_q.size() == 0) begin
          failures++;
          $display("FAIL out_unexpected actual=%0h required=none", act);
        end else begin
          exp = out_q.pop_front();
          if (act !== exp) begin
            failures++;
            $display("FAIL out_beat actual=%0h required=%0h at %0t", act, exp, $time);
          end else begin
            $display("out  beat sop=%0b eop=%0b re=%0h", act.sop, act.eop, act.re);
          end
        end
      end
    end
  end

  // Upstream producer. Expected sink beats are queued up front; the frame
  // length follows the legalised size. With abort_at >= 0 reset is raised
  // while beat abort_at is being presented.
  task automatic push_frame(input logic [4:0] cfgn, input logic inv, input int base,
                            input bit toggle, input int abort_at);
    logic [4:0] npts_exp;
    int len, n_push, k, cyc;
    bit acc;
    npts_exp = (cfgn == 5'd4 || cfgn == 5'd8 || cfgn == 5'd16) ? cfgn : 5'd16;
    len      = int'(npts_exp);
    n_push   = (abort_at >= 0) ? abort_at + 1 : len;
    for (int i = 0; i < n_push; i++)
      sink_q.push_back({(i == 0), (i == len - 1), 10'(base + i), ~10'(base + i), npts_exp, inv});
    @(posedge clk); #1;
    cfg_npts = cfgn; cfg_inverse = inv;
    in_valid = 1'b1; in_real = 10'(base); in_imag = ~10'(base);
    k = 0; cyc = 0;
    forever begin
      @(negedge clk);
      acc = in_ready;
      if (toggle && cyc >= 1) check("in_ready_mirrors_sink_ready", 32'(in_ready), 32'(sink_bus.ready));
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        k++;
        // Mid-frame config changes must not reach the core
        if (k == 1) begin cfg_npts = 5'd4; cfg_inverse = ~inv; end
      end
      if (k == len) begin in_valid = 1'b0; break; end
      in_real = 10'(base + k); in_imag = ~10'(base + k);
      if (abort_at >= 0 && k == abort_at) begin reset = 1'b1; break; end
      if (toggle) sink_bus.ready = ~sink_bus.ready;
      if (cyc > 200) begin
        check("push_frame_timeout", 32'(k), 32'(len));
        in_valid = 1'b0;
        break;
      end
    end
  endtask

  // Core-output producer; expected downstream beats queued as each is presented
  task automatic send_out(input int n, input logic [4:0] npts, input int base,
                          input int eop_at, input int err_at);
    int cyc;
    bit acc;
    @(posedge clk); #1;
    for (int k = 0; k < n; k++) begin
      src_bus.valid = 1'b1;
      src_bus.sop   = (k == 0);
      src_bus.eop   = (k == eop_at);
      src_bus.error = (k == err_at) ? 2'b01 : 2'b00;
      src_bus.re    = 14'(base + k);
      src_bus.im    = 14'h3fff - 14'(base + k);
      src_bus.npts  = npts;
      out_q.push_back({(k == 0), (k == eop_at), 14'(base + k), 14'h3fff - 14'(base + k)});
      cyc = 0;
      forever begin
        @(negedge clk);
        acc = src_bus.ready;
        @(posedge clk); #1;
        cyc++;
        if (acc) break;
        if (cyc > 200) begin
          check("send_out_timeout", 32'(k), 32'(n));
          break;
        end
      end
    end
    src_bus.valid = 1'b0; src_bus.sop = 1'b0; src_bus.eop = 1'b0; src_bus.error = 2'b00;
  endtask

  task automatic pulse_err_clr();
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; cfg_npts = 5'd8; cfg_inverse = 1'b0; err_clr = 1'b0;
    in_valid = 1'b1; in_real = '0; in_imag = '0; out_ready = 1'b1;
    sink_bus.ready = 1'b1;
    src_bus.valid = 1'b0; src_bus.sop = 1'b0; src_bus.eop = 1'b0; src_bus.error = 2'b00;
    src_bus.re = '0; src_bus.im = '0; src_bus.npts = 5'd16;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("core_reset_n_low", 32'(core_reset_n), 32'd0);
    check("reset_sink_valid", 32'(sink_bus.valid), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd0);
    check("reset_fftpts_in", 32'(sink_bus.npts), 32'd16);
    check("reset_inverse", 32'(inverse), 32'd1);
    check("reset_outstanding", 32'(outstanding), 32'd0);
    check("reset_sym_count", 32'(sym_count), 32'd0);
    check("reset_flags", 32'({cfg_err, framing_err, core_err}), 32'd0);
    check("sink_error_zero", 32'(sink_bus.error), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0; enable = 1'b1;

    // 8-point IFFT frame, continuous, then the core returns it
    push_frame(5'd8, 1'b1, 10, 1'b0, -1);
    check("t1_outstanding", 32'(outstanding), 32'd1);
    check("t1_fftpts_in_held", 32'(sink_bus.npts), 32'd8);
    check("t1_inverse_held", 32'(inverse), 32'd1);
    send_out(8, 5'd8, 100, 7, -1);
    @(negedge clk);
    check("t1_sym_count", 32'(sym_count), 32'd1);
    check("t1_outstanding_drained", 32'(outstanding), 32'd0);
    check("t1_no_errors", 32'({cfg_err, framing_err, core_err}), 32'd0);

    // 16-point FFT frame with sink_ready toggling each cycle
    push_frame(5'd16, 1'b0, 200, 1'b1, -1);
    sink_bus.ready = 1'b1;
    check("t2_all_beats_seen", 32'(sink_q.size()), 32'd0);
    check("t2_outstanding", 32'(outstanding), 32'd1);
    check("t2_inverse", 32'(inverse), 32'd0);

    // Frame limit: second frame fills the core, third waits for an output eop
    push_frame(5'd4, 1'b1, 300, 1'b0, -1);
    check("t3_outstanding_full", 32'(outstanding), 32'd2);
    out_ready = 1'b0;
    fork
      push_frame(5'd8, 1'b0, 400, 1'b0, -1);
      send_out(16, 5'd16, 500, 15, -1);
      begin
        repeat (4) @(negedge clk);
        check("t3_blocked_in_ready", 32'(in_ready), 32'd0);
        check("t3_blocked_sink_valid", 32'(sink_bus.valid), 32'd0);
        check("t3_blocked_outstanding", 32'(outstanding), 32'd2);
        check("t3_out_valid_stalled", 32'(out_valid), 32'd1);
        check("t3_source_ready_low", 32'(src_bus.ready), 32'd0);
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    check("t3_outstanding_after", 32'(outstanding), 32'd2);
    check("t3_fftpts_in", 32'(sink_bus.npts), 32'd8);
    send_out(4, 5'd4, 600, 3, -1);
    send_out(8, 5'd8, 700, 7, -1);
    @(negedge clk);
    check("t3_sym_count", 32'(sym_count), 32'd4);
    check("t3_outstanding_drained", 32'(outstanding), 32'd0);

    // Illegal size falls back to 16 and flags cfg_err
    push_frame(5'd5, 1'b1, 800, 1'b0, -1);
    check("t4_fftpts_default", 32'(sink_bus.npts), 32'd16);
    check("t4_cfg_err_set", 32'(cfg_err), 32'd1);
    pulse_err_clr();
    @(negedge clk);
    check("t4_cfg_err_cleared", 32'(cfg_err), 32'd0);
    send_out(16, 5'd16, 900, 15, -1);
    @(negedge clk);
    check("t4_sym_count", 32'(sym_count), 32'd5);

    // Early eop on an 8-point output frame
    push_frame(5'd8, 1'b1, 20, 1'b0, -1);
    send_out(4, 5'd8, 1000, 3, -1);
    @(negedge clk);
    check("t5_framing_err", 32'(framing_err), 32'd1);
    check("t5_core_err_clear", 32'(core_err), 32'd0);
    check("t5_outstanding", 32'(outstanding), 32'd0);
    check("t5_sym_count", 32'(sym_count), 32'd6);
    pulse_err_clr();
    @(negedge clk);
    check("t5_framing_err_cleared", 32'(framing_err), 32'd0);

    // Core error code on one beat
    push_frame(5'd4, 1'b1, 40, 1'b0, -1);
    send_out(4, 5'd4, 1100, 3, 1);
    @(negedge clk);
    check("t5_core_err", 32'(core_err), 32'd1);
    check("t5_framing_ok", 32'(framing_err), 32'd0);
    check("t5_sym_count_b", 32'(sym_count), 32'd7);

    // Output frame with nothing in flight: no underflow, framing error
    pulse_err_clr();
    send_out(4, 5'd4, 1200, 3, -1);
    @(negedge clk);
    check("t5_underflow_outstanding", 32'(outstanding), 32'd0);
    check("t5_underflow_framing_err", 32'(framing_err), 32'd1);
    check("t5_underflow_sym_count", 32'(sym_count), 32'd8);

    // Reset while beat 4 of a 16-point frame is on the sink
    push_frame(5'd16, 1'b0, 60, 1'b0, 4);
    @(posedge clk); #1;
    check("t6_sink_valid", 32'(sink_bus.valid), 32'd0);
    check("t6_outstanding", 32'(outstanding), 32'd0);
    check("t6_sym_count", 32'(sym_count), 32'd0);
    check("t6_fftpts_in", 32'(sink_bus.npts), 32'd16);
    check("t6_inverse", 32'(inverse), 32'd1);
    check("t6_flags", 32'({cfg_err, framing_err, core_err}), 32'd0);
    reset = 1'b0; in_valid = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("final_sink_q_empty", 32'(sink_q.size()), 32'd0);
    check("final_out_q_empty", 32'(out_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
